// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode / operand-fetch stage plus the ID/EX pipeline register that feeds
//   the vector ALU. Holds the 32 x 64 vector register file, reads rA/rB/rD
//   from the instruction in IF/ID, resolves BRANCH_EZ / BRANCH_NZ, detects
//   load-use hazards and registers instruction + operands for EX.
//
//   Bit numbering is big-endian throughout: instruction [0:31], data [0:DW-1].
//     [0:5] type  [6:10] rD  [11:15] rA  [16:20] rB  [24:25] WW
//     [26:31] ALU op  [16:31] imm
//
//   The register file is split into NUM_LANES slices of VEC_W bits. Each
//   slice is an id_ex_rf_lane instance, one per lane.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   IF_ID_Instr     instruction from IF/ID            IF_ID_valid  slot live
//   WB_wr_en        write-back enable                 WB_rD        WB index
//   WB_data         write-back data
//   stall           comb: hold PC and IF/ID this cycle (load-use hazard)
//   branch_taken    comb: redirect fetch
//   branch_target   comb: IF_ID_Instr[16:31]
//   ID_EX_Instr     registered instruction (NOP_I when bubble)
//   ID_EX_rA/rB/rD  registered operand values
//   ID_EX_valid     registered: EX slot holds a real instruction
//
// Configuration
//   WB_BYPASS_EN    defined: a register read that hits the same-cycle
//                   write-back returns WB_data (write-first), including the
//                   rD value used for branch evaluation.
//                   undefined: reads return the pre-write contents.
// ---------------------------------------------------------------------------

// One VEC_W-bit slice of every register, with three combinational read ports.
module id_ex_rf_lane #(
    parameter int NREG  = 32,
    parameter int VEC_W = 16,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_wr_en,
    input  logic [0:AW-1]    wb_idx,
    input  logic [0:VEC_W-1] wb_data,
    input  logic [0:AW-1]    rd_idx_a,
    input  logic [0:AW-1]    rd_idx_b,
    input  logic [0:AW-1]    rd_idx_d,
    output logic [0:VEC_W-1] rd_a,
    output logic [0:VEC_W-1] rd_b,
    output logic [0:VEC_W-1] rd_d,
    output logic             rd_d_zero
);
    logic [0:VEC_W-1] mem_q [NREG];
    logic [0:VEC_W-1] mem_d [NREG];

    // Index 0 is an ordinary register: writes to it are kept.
    always_comb begin
        for (int i = 0; i < NREG; i++) mem_d[i] = mem_q[i];
        if (wb_wr_en) mem_d[wb_idx] = wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
        end
    end

    function automatic logic [0:VEC_W-1] rd_port(input logic [0:AW-1] idx);
`ifdef WB_BYPASS_EN
        if (wb_wr_en && (wb_idx == idx)) return wb_data;
`endif
        return mem_q[idx];
    endfunction

    assign rd_a      = rd_port(rd_idx_a);
    assign rd_b      = rd_port(rd_idx_b);
    assign rd_d      = rd_port(rd_idx_d);
    assign rd_d_zero = ~|rd_d;
endmodule

module id_ex_stage #(
    parameter int          NREG      = 32,
    parameter int          DW        = 64,
    parameter logic [0:31] NOP_I     = 32'hF000_0000,
    parameter int          NUM_LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:31]  IF_ID_Instr,
    input  logic         IF_ID_valid,
    input  logic         WB_wr_en,
    input  logic [0:4]   WB_rD,
    input  logic [0:DW-1] WB_data,
    output logic         stall,
    output logic         branch_taken,
    output logic [0:15]  branch_target,
    output logic [0:31]  ID_EX_Instr,
    output logic [0:DW-1] ID_EX_rA,
    output logic [0:DW-1] ID_EX_rB,
    output logic [0:DW-1] ID_EX_rD,
    output logic         ID_EX_valid
);
    localparam int VEC_W = DW / NUM_LANES;

    localparam logic [0:5] T_LOAD      = 6'b100000;
    localparam logic [0:5] T_STORE     = 6'b100001;
    localparam logic [0:5] T_BRANCH_EZ = 6'b100010;
    localparam logic [0:5] T_BRANCH_NZ = 6'b100011;

    typedef struct packed {
        logic [0:31]   instr;
        logic [0:DW-1] ra;
        logic [0:DW-1] rb;
        logic [0:DW-1] rd;
        logic          valid;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '{instr: NOP_I, ra: '0, rb: '0, rd: '0, valid: 1'b0};

    id_ex_t id_ex_q, id_ex_d;

    // Decode of the instruction sitting in IF/ID.
    logic [0:5] id_type;
    logic [0:4] rd_idx, ra_idx, rb_idx;
    assign id_type = IF_ID_Instr[0:5];
    assign rd_idx  = IF_ID_Instr[6:10];
    assign ra_idx  = IF_ID_Instr[11:15];
    assign rb_idx  = IF_ID_Instr[16:20];

    // Register file, one slice per lane.
    logic [0:NUM_LANES-1][0:VEC_W-1] wb_lanes;
    logic [0:NUM_LANES-1][0:VEC_W-1] ra_lanes, rb_lanes, rd_lanes;
    logic [0:NUM_LANES-1]            rd_zero_lanes;

    assign wb_lanes = WB_data;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        id_ex_rf_lane #(
            .NREG  (NREG),
            .VEC_W (VEC_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .wb_wr_en  (WB_wr_en),
            .wb_idx    (WB_rD),
            .wb_data   (wb_lanes[g]),
            .rd_idx_a  (ra_idx),
            .rd_idx_b  (rb_idx),
            .rd_idx_d  (rd_idx),
            .rd_a      (ra_lanes[g]),
            .rd_b      (rb_lanes[g]),
            .rd_d      (rd_lanes[g]),
            .rd_d_zero (rd_zero_lanes[g])
        );
    end

    logic [0:DW-1] ra_val, rb_val, rd_val;
    assign ra_val = ra_lanes;
    assign rb_val = rb_lanes;
    assign rd_val = rd_lanes;

    logic is_store, is_bez, is_bnz, is_branch, uses_rd;
    logic ex_is_load, hazard, issue, rd_zero;
    logic [0:4] ex_rd_idx;

    always_comb begin
        is_store   = (id_type == T_STORE);
        is_bez     = (id_type == T_BRANCH_EZ);
        is_bnz     = (id_type == T_BRANCH_NZ);
        is_branch  = is_bez | is_bnz;
        uses_rd    = is_store | is_branch;
        ex_rd_idx  = id_ex_q.instr[6:10];
        ex_is_load = id_ex_q.valid && (id_ex_q.instr[0:5] == T_LOAD);

        // The bubble inserted on a stall clears ex_is_load next cycle, so a
        // stall can never last longer than one cycle.
        hazard = IF_ID_valid && ex_is_load &&
                 ((ex_rd_idx == ra_idx) || (ex_rd_idx == rb_idx) ||
                  (uses_rd && (ex_rd_idx == rd_idx)));
        issue   = IF_ID_valid && !hazard;
        rd_zero = &rd_zero_lanes;

        // Branches resolve here and never occupy the EX slot.
        id_ex_d = BUBBLE;
        if (issue && !is_branch) begin
            id_ex_d = '{instr: IF_ID_Instr, ra: ra_val, rb: rb_val, rd: rd_val, valid: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) id_ex_q <= BUBBLE;
        else        id_ex_q <= id_ex_d;
    end

    assign stall         = hazard;
    assign branch_taken  = issue && ((is_bez && rd_zero) || (is_bnz && !rd_zero));
    assign branch_target = IF_ID_Instr[16:31];
    assign ID_EX_Instr   = id_ex_q.instr;
    assign ID_EX_rA      = id_ex_q.ra;
    assign ID_EX_rB      = id_ex_q.rb;
    assign ID_EX_rD      = id_ex_q.rd;
    assign ID_EX_valid   = id_ex_q.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    localparam logic [31:0] NOP = 32'hF000_0000;
    localparam logic [5:0] T_ALU = 6'b101010, T_LOAD = 6'b100000, T_STORE = 6'b100001,
                           T_BEZ = 6'b100010, T_BNZ = 6'b100011;
    localparam logic [5:0] OP_VADD = 6'd1, OP_VAND = 6'd2, OP_VXOR = 6'd5, OP_VMOV = 6'd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_valid;
    logic        WB_wr_en;
    logic [4:0]  WB_rD;
    logic [63:0] WB_data;
    logic        stall, branch_taken, ID_EX_valid;
    logic [15:0] branch_target;
    logic [31:0] ID_EX_Instr;
    logic [63:0] ID_EX_rA, ID_EX_rB, ID_EX_rD;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .IF_ID_Instr(IF_ID_Instr), .IF_ID_valid(IF_ID_valid),
        .WB_wr_en(WB_wr_en), .WB_rD(WB_rD), .WB_data(WB_data), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ID_EX_Instr(ID_EX_Instr), .ID_EX_rA(ID_EX_rA), .ID_EX_rB(ID_EX_rB),
        .ID_EX_rD(ID_EX_rD), .ID_EX_valid(ID_EX_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        bit          v;
        bit          we;
        logic [4:0]  wrd;
        logic [63:0] wdata;
        bit          es, et, ev;   // expected stall, branch_taken, ID_EX_valid
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] ra, rb, rd;
        bit          valid;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    logic [63:0] model [32];
    int          nvec = 0;
    int          nerr = 0;

    function automatic logic [31:0] alu(input logic [5:0] t, input logic [4:0] d, a, b,
                                        input logic [5:0] op);
        return {t, d, a, b, 3'b000, 2'b00, op};
    endfunction

    function automatic logic [31:0] br(input logic [5:0] t, input logic [4:0] d,
                                       input logic [15:0] imm);
        return {t, d, 5'd0, imm};
    endfunction

    function automatic vec_t mkv(input logic [31:0] i, input bit v, input bit we,
                                 input logic [4:0] wrd, input logic [63:0] wd,
                                 input bit es, input bit et, input bit ev);
        vec_t r;
        r.instr = i; r.v = v; r.we = we; r.wrd = wrd; r.wdata = wd;
        r.es = es; r.et = et; r.ev = ev;
        return r;
    endfunction

    function automatic logic [63:0] mread(input vec_t v, input logic [4:0] idx);
`ifdef WB_BYPASS_EN
        if (v.we && v.wrd == idx) return v.wdata;
`endif
        return model[idx];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_instr", ID_EX_Instr, NOP);
        chk("rst_valid", ID_EX_valid, 0);
        chk("rst_rA", ID_EX_rA, 0);
        chk("rst_rB", ID_EX_rB, 0);
        chk("rst_rD", ID_EX_rD, 0);
        chk("rst_stall", stall, 0);
        chk("rst_taken", branch_taken, 0);
    endtask

    // Called at posedge+1; drives one cycle, checks comb outputs, then the
    // registered result after the next edge.
    task automatic apply(input vec_t v);
        exp_t e;
        IF_ID_Instr = v.instr; IF_ID_valid = v.v;
        WB_wr_en = v.we; WB_rD = v.wrd; WB_data = v.wdata;
        #1;
        chk("stall", stall, v.es);
        chk("branch_taken", branch_taken, v.et);
        chk("branch_target", branch_target, v.instr[15:0]);
        if (v.ev) begin
            e.instr = v.instr; e.valid = 1'b1;
            e.ra = mread(v, v.instr[20:16]);
            e.rb = mread(v, v.instr[15:11]);
            e.rd = mread(v, v.instr[25:21]);
        end else begin
            e.instr = NOP; e.valid = 1'b0; e.ra = '0; e.rb = '0; e.rd = '0;
        end
        sb.push_back(e);
        if (v.we) model[v.wrd] = v.wdata;
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL scoreboard: empty, expected an entry");
        end else begin
            e = sb.pop_front();
            chk("ID_EX_Instr", ID_EX_Instr, e.instr);
            chk("ID_EX_valid", ID_EX_valid, e.valid);
            chk("ID_EX_rA", ID_EX_rA, e.ra);
            chk("ID_EX_rB", ID_EX_rB, e.rb);
            chk("ID_EX_rD", ID_EX_rD, e.rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        rst_n = 1'b0; IF_ID_Instr = NOP; IF_ID_valid = 1'b0;
        WB_wr_en = 1'b0; WB_rD = '0; WB_data = '0;

        // issue
        tbl.push_back(mkv(NOP, 0, 1, 5'd1, 64'h0102_0304_0506_0708, 0, 0, 0));
        tbl.push_back(mkv(NOP, 0, 1, 5'd2, 64'h1111_1111_1111_1111, 0, 0, 0));
        tbl.push_back(mkv(alu(T_ALU, 5'd0, 5'd1, 5'd2, OP_VADD), 1, 0, 0, 0, 0, 0, 1));
        // load-use on rA, then retry
        tbl.push_back(mkv(alu(T_LOAD, 5'd3, 5'd0, 5'd0, 6'd0), 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkv(alu(T_ALU, 5'd4, 5'd3, 5'd2, OP_VAND), 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(alu(T_ALU, 5'd4, 5'd3, 5'd2, OP_VAND), 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkv(alu(T_ALU, 5'd6, 5'd1, 5'd2, OP_VXOR), 1, 0, 0, 0, 0, 0, 1));
        // dependent consumer not valid: no stall
        tbl.push_back(mkv(alu(T_LOAD, 5'd3, 5'd0, 5'd0, 6'd0), 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkv(alu(T_ALU, 5'd4, 5'd3, 5'd2, OP_VAND), 0, 0, 0, 0, 0, 0, 0));
        // load then branch on its rD: stall suppresses the branch, retry takes it
        tbl.push_back(mkv(alu(T_LOAD, 5'd5, 5'd0, 5'd0, 6'd0), 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkv(br(T_BEZ, 5'd5, 16'h0040), 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(br(T_BEZ, 5'd5, 16'h0040), 1, 0, 0, 0, 0, 1, 0));
        // load then store of its rD
        tbl.push_back(mkv(alu(T_LOAD, 5'd6, 5'd0, 5'd0, 6'd0), 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkv(alu(T_STORE, 5'd6, 5'd1, 5'd2, 6'd0), 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mkv(alu(T_STORE, 5'd6, 5'd1, 5'd2, 6'd0), 1, 0, 0, 0, 0, 0, 1));
        // rD match on a plain ALU op does not stall
        tbl.push_back(mkv(alu(T_LOAD, 5'd6, 5'd0, 5'd0, 6'd0), 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkv(alu(T_ALU, 5'd6, 5'd1, 5'd2, OP_VXOR), 1, 0, 0, 0, 0, 0, 1));
        // branches
        tbl.push_back(mkv(NOP, 0, 1, 5'd5, 64'h0, 0, 0, 0));
        tbl.push_back(mkv(br(T_BEZ, 5'd5, 16'h0040), 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(NOP, 0, 1, 5'd5, 64'h1, 0, 0, 0));
        tbl.push_back(mkv(br(T_BEZ, 5'd5, 16'h0040), 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(br(T_BNZ, 5'd5, 16'h1234), 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mkv(br(T_BNZ, 5'd5, 16'h1234), 0, 0, 0, 0, 0, 0, 0));
        // r0 is writable
        tbl.push_back(mkv(NOP, 0, 1, 5'd0, 64'hA5A5_5A5A_A5A5_5A5A, 0, 0, 0));
        tbl.push_back(mkv(alu(T_ALU, 5'd1, 5'd0, 5'd0, OP_VMOV), 1, 0, 0, 0, 0, 0, 1));
        // same-cycle write-back vs read
        tbl.push_back(mkv(NOP, 0, 1, 5'd7, 64'h7777_0000_7777_0000, 0, 0, 0));
        tbl.push_back(mkv(alu(T_ALU, 5'd8, 5'd7, 5'd0, OP_VMOV), 1, 1, 5'd7,
                          64'hDEAD_BEEF_0000_0001, 0, 0, 1));
        tbl.push_back(mkv(alu(T_ALU, 5'd8, 5'd7, 5'd0, OP_VMOV), 1, 0, 0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // back-to-back independent VXORs
        for (int i = 0; i < 8; i++)
            apply(mkv(alu(T_ALU, 5'(16 + i), 5'(i), 5'(8 + i), OP_VXOR), 1, 0, 0, 0, 0, 0, 1));

        // reset while an instruction and a write-back are in flight
        IF_ID_Instr = alu(T_ALU, 5'd0, 5'd1, 5'd2, OP_VADD); IF_ID_valid = 1'b1;
        WB_wr_en = 1'b1; WB_rD = 5'd9; WB_data = 64'h9999_9999_9999_9999;
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset();
        IF_ID_valid = 1'b0; WB_wr_en = 1'b0;
        @(posedge clk); #1;
        chk_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        sb.delete();
        apply(mkv(alu(T_ALU, 5'd2, 5'd9, 5'd1, OP_VMOV), 1, 0, 0, 0, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
